// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and helper functions for the set-associative icache
package icache_pkg;

  // Miss-handling FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REQ,
    ST_WAIT
  } state_e;

  // Tree-PLRU bits for up to 4 ways: [0] root, [1] left pair, [2] right pair
  typedef logic [2:0] plru_t;

  function automatic int idx_width(input int set_num);
    return $clog2(set_num);
  endfunction

  function automatic int tag_width(input int addr_width, input int set_num);
    return addr_width - $clog2(set_num) - 2;
  endfunction

  // Point every node on the path to the accessed way towards the other half
  function automatic plru_t plru_update(input plru_t bits, input logic [1:0] way, input int way_num);
    plru_t nxt;
    nxt = bits;
    if (way_num == 2) begin
      nxt[0] = ~way[0];
    end else if (way_num == 4) begin
      nxt[0] = ~way[1];
      if (way[1]) nxt[2] = ~way[0];
      else        nxt[1] = ~way[0];
    end
    return nxt;
  endfunction

  // Follow the tree bits down to the least recently used way
  function automatic logic [1:0] plru_victim(input plru_t bits, input int way_num);
    logic [1:0] v;
    v = 2'b00;
    if (way_num == 2) begin
      v = {1'b0, bits[0]};
    end else if (way_num == 4) begin
      v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    end
    return v;
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// rtl/icache_sa_if.sv - IQ/FC/ROB signal bundle for the set-associative icache
interface icache_sa_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [AddrWidth-1:0] pc_from_iq;
  logic                 is_empty_from_iq;
  logic [DataWidth-1:0] instr_from_fc;
  logic                 is_instr_from_fc;
  logic                 is_commit_from_fc;
  logic                 is_exception_from_rob;
  logic                 is_flush_from_rob;
  logic [AddrWidth-1:0] addr_to_fc;
  logic                 is_empty_to_fc;
  logic                 is_hit_to_iq;
  logic [DataWidth-1:0] instr_to_iq;

  // Environment side: IQ, FC and ROB
  modport master (
    output pc_from_iq, is_empty_from_iq, instr_from_fc, is_instr_from_fc,
    output is_commit_from_fc, is_exception_from_rob, is_flush_from_rob,
    input  addr_to_fc, is_empty_to_fc, is_hit_to_iq, instr_to_iq
  );

  // Cache side
  modport slave (
    input  pc_from_iq, is_empty_from_iq, instr_from_fc, is_instr_from_fc,
    input  is_commit_from_fc, is_exception_from_rob, is_flush_from_rob,
    output addr_to_fc, is_empty_to_fc, is_hit_to_iq, instr_to_iq
  );
endinterface

// File: rtl/icache_plru.sv
// rtl/icache_plru.sv - per-set tree-PLRU state with victim read and update ports
module icache_plru
  import icache_pkg::*;
#(
  parameter int SetNum = 64,
  parameter int WayNum = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic [$clog2(SetNum)-1:0] vic_idx_i,
  output logic [1:0]                vic_way_o,
  input  logic                      upd_en_i,
  input  logic [$clog2(SetNum)-1:0] upd_idx_i,
  input  logic [1:0]                upd_way_i
);

  plru_t plru_q [SetNum];

  // Clear on reset or whole-cache invalidate, otherwise age the accessed set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SetNum; s++) plru_q[s] <= '0;
    end else if (clr_i) begin
      for (int s = 0; s < SetNum; s++) plru_q[s] <= '0;
    end else if (upd_en_i) begin
      plru_q[upd_idx_i] <= plru_update(plru_q[upd_idx_i], upd_way_i, WayNum);
    end
  end

  assign vic_way_o = plru_victim(plru_q[vic_idx_i], WayNum);

endmodule

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache between IQ and FC; ICACHE_STATS_EN adds hit/miss counters
module icache_sa
  import icache_pkg::*;
#(
  parameter int SetNum    = 64,
  parameter int WayNum    = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic clk,
  input  logic rst,
  icache_sa_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IdxW = idx_width(SetNum);
  localparam int TagW = tag_width(AddrWidth, SetNum);
  localparam int WayW = (WayNum > 1) ? $clog2(WayNum) : 1;

  // Storage: valid bits reset, tag/data arrays only written on fills
  logic [WayNum-1:0]    valid_q [SetNum];
  logic [TagW-1:0]      tag_q   [SetNum][WayNum];
  logic [DataWidth-1:0] data_q  [SetNum][WayNum];

  state_e               state_q;
  logic [AddrWidth-1:0] pc_q;
  logic                 cmp_done_q;
  logic [WayNum-1:0]    match_q;
  logic [WayW-1:0]      victim_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 req_n_q;
  logic                 hit_q;
  logic [DataWidth-1:0] instr_q;

  logic [IdxW-1:0]      idx;
  logic [TagW-1:0]      tag;
  logic [WayNum-1:0]    match_d;
  logic [WayW-1:0]      hit_way_d;
  logic [WayW-1:0]      victim_d;
  logic [1:0]           plru_vic;
  logic                 abort;
  logic                 fill;
  logic                 lookup_hit;
  logic                 lookup_miss;
  logic                 fill_we;
  logic                 plru_upd_en;
  logic [1:0]           plru_upd_way;

  assign idx   = pc_q[IdxW+1:2];
  assign tag   = pc_q[AddrWidth-1:IdxW+2];
  assign abort = bus.is_exception_from_rob | bus.is_flush_from_rob;
  assign fill  = bus.is_commit_from_fc & bus.is_instr_from_fc;

  // Tag match, hit-way encode and victim choice for the latched index
  always_comb begin
    match_d   = '0;
    hit_way_d = '0;
    victim_d  = WayW'(plru_vic);
    for (int w = 0; w < WayNum; w++) begin
      match_d[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    end
    for (int w = WayNum - 1; w >= 0; w--) begin
      if (match_q[w]) hit_way_d = WayW'(w);
      if (!valid_q[idx][w]) victim_d = WayW'(w);
    end
  end

  // The tag compare is registered, so LOOKUP acts on its second cycle
  assign lookup_hit   = (state_q == ST_LOOKUP) && cmp_done_q && (|match_q) && !abort;
  assign lookup_miss  = (state_q == ST_LOOKUP) && cmp_done_q && !(|match_q) && !abort;
  assign fill_we      = (state_q == ST_WAIT) && fill && !abort;
  assign plru_upd_en  = lookup_hit | fill_we;
  assign plru_upd_way = 2'(lookup_hit ? hit_way_d : victim_q);

  icache_plru #(
    .SetNum (SetNum),
    .WayNum (WayNum)
  ) u_plru (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.is_flush_from_rob),
    .vic_idx_i (idx),
    .vic_way_o (plru_vic),
    .upd_en_i  (plru_upd_en),
    .upd_idx_i (idx),
    .upd_way_i (plru_upd_way)
  );

  // Valid bits: flush clears everything, a surviving fill sets the victim way
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SetNum; s++) valid_q[s] <= '0;
    end else if (bus.is_flush_from_rob) begin
      for (int s = 0; s < SetNum; s++) valid_q[s] <= '0;
    end else if (fill_we) begin
      valid_q[idx][victim_q] <= 1'b1;
    end
  end

  // Tag and data arrays written with the fill word
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx][victim_q]  <= tag;
      data_q[idx][victim_q] <= bus.instr_from_fc;
    end
  end

  // Miss FSM with registered IQ/FC outputs; exception or flush aborts from any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      cmp_done_q <= 1'b0;
      match_q    <= '0;
      victim_q   <= '0;
      addr_q     <= '0;
      req_n_q    <= 1'b1;
      hit_q      <= 1'b0;
      instr_q    <= '0;
    end else begin
      hit_q   <= 1'b0;
      req_n_q <= 1'b1;
      if (abort) begin
        state_q    <= ST_IDLE;
        cmp_done_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!bus.is_empty_from_iq) begin
              pc_q       <= bus.pc_from_iq;
              cmp_done_q <= 1'b0;
              state_q    <= ST_LOOKUP;
            end
          end
          ST_LOOKUP: begin
            if (!cmp_done_q) begin
              match_q    <= match_d;
              cmp_done_q <= 1'b1;
            end else if (|match_q) begin
              hit_q   <= 1'b1;
              instr_q <= data_q[idx][hit_way_d];
              state_q <= ST_IDLE;
            end else begin
              victim_q <= victim_d;
              addr_q   <= pc_q;
              req_n_q  <= 1'b0;
              state_q  <= ST_REQ;
            end
          end
          ST_REQ: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (fill) begin
              hit_q   <= 1'b1;
              instr_q <= bus.instr_from_fc;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.addr_to_fc     = addr_q;
  assign bus.is_empty_to_fc = req_n_q;
  assign bus.is_hit_to_iq   = hit_q;
  assign bus.instr_to_iq    = instr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating LOOKUP outcome counters, untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
